// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing types and default sizes for the bundling datapath.
package hdc_pkg;
  localparam int D_DEF  = 64;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;
endpackage

// File: rtl/hv_lane_ctr.sv
// One bundling lane: counts set input bits, clear has priority over increment.
// Saturates at all-ones when HV_BUNDLER_SAT_EN is defined, otherwise wraps.
module hv_lane_ctr
  import hdc_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_bit,
  output logic [CW-1:0] o_cnt_nxt
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nxt;

  // o_cnt_nxt includes this cycle's increment so the bundle result can be
  // captured on the same edge as the final vector.
  always_comb begin
    w_nxt = r_cnt;
    if (i_en && i_bit) begin
`ifdef HV_BUNDLER_SAT_EN
      if (r_cnt != {CW{1'b1}}) w_nxt = CW'(r_cnt + 1'b1);
`else
      w_nxt = CW'(r_cnt + 1'b1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else            r_cnt <= w_nxt;
  end

  assign o_cnt_nxt = w_nxt;

endmodule

// File: rtl/hv_bundler.sv
// Majority bundler of binary hypervectors; result valid 1 cycle after the last handshake,
// input stalls while the result waits on out_ready. Counter saturation: HV_BUNDLER_SAT_EN.
module hv_bundler
  import hdc_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [D-1:0]  in_hv,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [D-1:0]  out_hv,
  output logic [CW-1:0] out_cnt
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [D-1:0]  r_out_hv;
  logic [CW-1:0] r_out_cnt;

  logic          w_in_hs;
  logic          w_out_hs;
  logic          w_load;
  logic          w_ctr_clr;
  logic [CW-1:0] w_n_nxt;
  logic [CW-1:0] w_acc_nxt [D];
  logic [D-1:0]  w_maj;

  assign in_ready  = (r_state != OUT);
  assign out_valid = (r_state == OUT);

  // clr swallows a coincident input so it never reaches the counters.
  assign w_in_hs   = in_valid & in_ready & ~clr;
  assign w_out_hs  = out_valid & out_ready;
  assign w_load    = w_in_hs & in_last;
  assign w_ctr_clr = clr | w_out_hs;

  hv_lane_ctr #(.CW(CW)) u_n_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_ctr_clr),
    .i_en      (w_in_hs),
    .i_bit     (1'b1),
    .o_cnt_nxt (w_n_nxt)
  );

  for (genvar g = 0; g < D; g++) begin : g_lane
    hv_lane_ctr #(.CW(CW)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_ctr_clr),
      .i_en      (w_in_hs),
      .i_bit     (in_hv[g]),
      .o_cnt_nxt (w_acc_nxt[g])
    );
    // Strict majority at CW+1 bits; a tie resolves to 0.
    assign w_maj[g] = ({w_acc_nxt[g], 1'b0} > {1'b0, w_n_nxt});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE, ACC: if (w_in_hs) w_state_nxt = in_last ? OUT : ACC;
        OUT:       if (w_out_hs) w_state_nxt = IDLE;
        default:   w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_hv  <= '0;
      r_out_cnt <= '0;
    end else if (clr) begin
      r_out_hv  <= '0;
      r_out_cnt <= '0;
    end else if (w_load) begin
      r_out_hv  <= w_maj;
      r_out_cnt <= w_n_nxt;
    end
  end

  assign out_hv  = r_out_hv;
  assign out_cnt = r_out_cnt;

endmodule

// File: doc/hv_bundler.md
HV_BUNDLER -- requirements
Module: hv_bundler

Interface
REQ-001 SHALL have parameter D, default 64, number of hypervector lanes (bits per hypervector).
REQ-002 SHALL have parameter CW, default 8, per-lane counter width and bundle-count width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous abort: zero all counters, return to IDLE.
REQ-006 SHALL have port in_valid  input  1  input hypervector valid.
REQ-007 SHALL have port in_ready  output  1  block accepts an input hypervector.
REQ-008 SHALL have port in_hv  input  D  binary hypervector to bundle.
REQ-009 SHALL have port in_last  input  1  marks the final hypervector of the bundle; qualified by in_valid.
REQ-010 SHALL have port out_valid  output  1  bundled result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_hv  output  D  majority-thresholded hypervector.
REQ-013 SHALL have port out_cnt  output  CW  number of hypervectors bundled into out_hv.

Function
REQ-014 SHALL implement states IDLE, ACC, OUT; input handshake = in_valid & in_ready; output handshake = out_valid & out_ready.
REQ-015 SHALL drive in_ready=1 in IDLE and ACC, 0 in OUT; out_valid=1 only in OUT.
REQ-016 SHALL, on each input handshake, increment lane counter i by in_hv[i] for every i in parallel, and increment bundle count n by 1.
REQ-017 SHALL transition IDLE->ACC on input handshake with in_last=0; IDLE->OUT or ACC->OUT on input handshake with in_last=1; ACC->ACC otherwise.
REQ-018 SHALL include the in_last vector in the counts; out_valid SHALL rise the cycle after the in_last handshake (latency 1), so n>=1 in OUT.
REQ-019 SHALL set out_hv[i]=1 iff 2*acc[i] > n, computed at CW+1 bits (no overflow); tie (2*acc[i]==n) yields 0.
REQ-020 SHALL register out_hv and out_cnt=n on entry to OUT and hold them stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, on output handshake, go OUT->IDLE and zero all lane counters and n on the same edge; next input accepted the following cycle.
REQ-022 SHALL give clr priority over every other event: any state -> IDLE, counters zeroed, out_valid dropped next cycle, a coincident input handshake discarded.
REQ-023 SHALL ignore in_hv and in_last when in_valid=0.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, all lane counters and n to 0, out_hv=0, out_cnt=0, out_valid=0, in_ready=1 after deassertion.
REQ-025 SHALL discard any partial bundle when reset asserts mid-bundle or in OUT.

Configuration
REQ-026 SHALL support macro HV_BUNDLER_SAT_EN: defined -> every lane counter and n saturate at 2^CW-1 (further increments hold the value).
REQ-027 SHALL, without HV_BUNDLER_SAT_EN, let lane counters and n wrap modulo 2^CW; bundles longer than 2^CW-1 are then undefined usage.

Structure
REQ-028 SHALL place the state enum (IDLE/ACC/OUT) and default D/CW constants in shared package hdc_pkg.
REQ-029 SHALL implement one lane as sub-module hv_lane_ctr (clr, en, bit input, CW-bit count, saturation per macro), instantiated D times via generate.

Verification (D=8, CW=4)
REQ-030 Three vectors 0xFF, 0x0F, 0x03 with in_last on third -> out_valid 1 cycle later, out_hv=0x0F, out_cnt=3.
REQ-031 Two vectors 0xF0, 0x3C with last -> ties on lanes 2,3,6,7 give 0; out_hv=0x30, out_cnt=2.
REQ-032 Hold out_ready=0 for 5 cycles in OUT with in_valid=1 -> in_ready=0, out_hv/out_cnt stable, no counts change; release -> IDLE, next bundle starts from zero.
REQ-033 Assert clr mid-bundle after two 0xFF vectors, then one 0x01 with last -> out_hv=0x01, out_cnt=1.
REQ-034 Twenty 0xFF vectors, last on 20th: with HV_BUNDLER_SAT_EN -> out_cnt=15, out_hv=0xFF; without -> out_cnt=4.
REQ-035 Assert rst_n=0 in ACC and in OUT -> all outputs 0 asynchronously, in_ready=1 after release.
